// File: rtl/menu_pkg.sv
// Shared definitions for the menu sequencer: FSM states, screen-select codes and the
// PS/2 make codes the menu reacts to.
package menu_pkg;

  typedef enum logic [1:0] {MENU, CONFIRM, GAME, PAUSE} menu_state_e;

  localparam logic [1:0] SCR_MENU  = 2'd0;
  localparam logic [1:0] SCR_GAME  = 2'd1;
  localparam logic [1:0] SCR_PAUSE = 2'd2;
  localparam logic [1:0] SCR_BLANK = 2'd3;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

endpackage

// File: rtl/frame_tick.sv
// Registers vertical blanking and flags its first cycle as the frame tick.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vblnk_in,
  output logic tick
);

  logic vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
    end
  end

  assign tick = vblnk_in & ~vblnk_q;

endmodule

// File: rtl/menu_ctrl.sv
// Menu sequencer for the 800x600 VGA frontend; every visible change commits at vblank start.
// Define MENU_WRAP_EN to make Up/Down wrap around the item list instead of saturating.
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int unsigned ITEMS          = 3,
  parameter int unsigned CONFIRM_FRAMES = 30,
  parameter int unsigned IDX_W          = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  output logic             key_ready,
  output logic [IDX_W-1:0] sel_idx,
  output logic [1:0]       screen_sel,
  output logic             game_start,
  output logic             exit_req
);

  localparam int unsigned      CNT_W    = (CONFIRM_FRAMES > 1) ? $clog2(CONFIRM_FRAMES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITEMS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM_FRAMES - 1);

  menu_state_e      state_q, state_d;
  logic [IDX_W-1:0] pending_q, pending_d, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_vld_q;
  logic [7:0]       key_q;
  logic [1:0]       screen_d;
  logic             game_start_d, exit_req_d;
  logic             tick, key_take;

  frame_tick u_frame_tick (
    .clk      (clk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .tick     (tick)
  );

  assign key_take = key_valid & key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MENU;
      pending_q  <= '0;
      cnt_q      <= '0;
      key_vld_q  <= 1'b0;
      key_q      <= '0;
      sel_idx    <= '0;
      screen_sel <= SCR_MENU;
      game_start <= 1'b0;
      exit_req   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      sel_idx    <= sel_d;
      screen_sel <= screen_d;
      game_start <= game_start_d;
      exit_req   <= exit_req_d;
      // key_ready is low while a key is latched, so a take and a commit never coincide
      if (key_take) begin
        key_vld_q <= 1'b1;
        key_q     <= key_code;
      end else if (tick) begin
        key_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (tick) begin
      unique case (state_q)
        MENU: begin
          if (key_vld_q) begin
            case (key_q)
              KEY_UP: begin
`ifdef MENU_WRAP_EN
                pending_d = (pending_q == '0) ? LAST_IDX : pending_q - IDX_W'(1);
`else
                if (pending_q != '0) pending_d = pending_q - IDX_W'(1);
`endif
              end
              KEY_DOWN: begin
`ifdef MENU_WRAP_EN
                pending_d = (pending_q == LAST_IDX) ? '0 : pending_q + IDX_W'(1);
`else
                if (pending_q != LAST_IDX) pending_d = pending_q + IDX_W'(1);
`endif
              end
              KEY_ENTER: begin
                if (pending_q == '0) begin
                  state_d = CONFIRM;
                  cnt_d   = '0;
                end
              end
              default: ;
            endcase
          end
        end
        CONFIRM: begin
          if (cnt_q == CNT_LAST) state_d = GAME;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        GAME: begin
          if (key_vld_q && key_q == KEY_ESC) state_d = PAUSE;
        end
        PAUSE: begin
          if (key_vld_q && key_q == KEY_ESC) begin
            state_d = GAME;
          end else if (key_vld_q && key_q == KEY_ENTER) begin
            state_d   = MENU;
            pending_d = '0;
          end
        end
        default: state_d = MENU;
      endcase
    end
  end

  always_comb begin
    key_ready    = ~rst & ~key_vld_q & (state_q != CONFIRM);
    sel_d        = tick ? pending_d : sel_idx;
    game_start_d = tick & (state_q == CONFIRM) & (state_d == GAME);
    exit_req_d   = tick & (state_q == MENU) & key_vld_q & (key_q == KEY_ENTER) &
                   (pending_q == LAST_IDX);
    screen_d     = SCR_MENU;
    unique case (state_d)
      MENU:    screen_d = SCR_MENU;
      CONFIRM: screen_d = SCR_BLANK;
      GAME:    screen_d = SCR_GAME;
      PAUSE:   screen_d = SCR_PAUSE;
      default: screen_d = SCR_MENU;
    endcase
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// Self-checking bench for menu_ctrl: directed table, hand-written corner sequences and a
// randomized run compared every cycle against a behavioural model.
module tb_menu_ctrl;

  localparam int ITEMS = 3;
  localparam int CF    = 4;

  localparam logic [7:0] K_UP    = 8'h75;
  localparam logic [7:0] K_DOWN  = 8'h72;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_ESC   = 8'h76;

  // Screen codes double as the model's notion of which mode the menu is in.
  localparam int SC_MENU  = 0;
  localparam int SC_GAME  = 1;
  localparam int SC_PAUSE = 2;
  localparam int SC_BLANK = 3;

`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk_in = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ready;
  logic [1:0] sel_idx;
  logic [1:0] screen_sel;
  logic       game_start;
  logic       exit_req;

  menu_ctrl #(
    .ITEMS          (ITEMS),
    .CONFIRM_FRAMES (CF),
    .IDX_W          (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .sel_idx    (sel_idx),
    .screen_sel (screen_sel),
    .game_start (game_start),
    .exit_req   (exit_req)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_exit   = 0;

  int         m_screen = SC_MENU;
  int         m_idx    = 0;
  int         m_frames = 0;
  bit         m_has_key = 1'b0;
  logic [7:0] m_key = 8'h00;
  bit         m_prev_vb = 1'b0;
  bit         m_start = 1'b0;
  bit         m_exit  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_commit(input logic [7:0] code);
    if (m_screen == SC_MENU) begin
      if (code == K_UP) begin
        if (m_idx > 0) m_idx = m_idx - 1;
        else if (WRAP) m_idx = ITEMS - 1;
      end else if (code == K_DOWN) begin
        if (m_idx < ITEMS - 1) m_idx = m_idx + 1;
        else if (WRAP) m_idx = 0;
      end else if (code == K_ENTER) begin
        if (m_idx == 0) begin
          m_screen = SC_BLANK;
          m_frames = 0;
        end else if (m_idx == ITEMS - 1) begin
          m_exit = 1'b1;
        end
      end
    end else if (m_screen == SC_GAME) begin
      if (code == K_ESC) m_screen = SC_PAUSE;
    end else if (m_screen == SC_PAUSE) begin
      if (code == K_ESC) m_screen = SC_GAME;
      else if (code == K_ENTER) begin
        m_screen = SC_MENU;
        m_idx    = 0;
      end
    end
  endtask

  // One clock: check the handshake, advance the model across the edge, check the outputs.
  task automatic cycle();
    logic exp_ready, acc, tk;
    #2;
    exp_ready = !rst && !m_has_key && (m_screen != SC_BLANK);
    check("key_ready", key_ready, exp_ready);
    acc = key_valid && exp_ready;
    tk  = vblnk_in && !m_prev_vb;
    @(posedge clk);
    #1;
    if (rst) begin
      m_screen = SC_MENU; m_idx = 0; m_frames = 0; m_has_key = 1'b0;
      m_prev_vb = 1'b0; m_start = 1'b0; m_exit = 1'b0;
    end else begin
      m_start = 1'b0;
      m_exit  = 1'b0;
      if (tk) begin
        if (m_screen == SC_BLANK) begin
          m_frames++;
          if (m_frames == CF) begin
            m_screen = SC_GAME;
            m_start  = 1'b1;
          end
        end else if (m_has_key) begin
          model_commit(m_key);
          m_has_key = 1'b0;
        end
      end
      if (acc) begin
        m_has_key = 1'b1;
        m_key     = key_code;
        key_valid = 1'b0;
      end
      m_prev_vb = vblnk_in;
    end
    check("sel_idx", sel_idx, m_idx);
    check("screen_sel", screen_sel, m_screen);
    check("game_start", game_start, m_start);
    check("exit_req", exit_req, m_exit);
    if (game_start) n_start++;
    if (exit_req) n_exit++;
  endtask

  task automatic frame();
    vblnk_in = 1'b0;
    repeat (6) cycle();
    vblnk_in = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; vblnk_in = 1'b0; key_valid = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    bit         has_key;
    logic [7:0] code;
    int         frames;
    int         sel;
    int         scr;
    int         starts;
    int         exits;
  } vec_t;

  vec_t tbl[22];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00,   3, 0,             SC_MENU,  0, 0};
    tbl[1]  = '{1'b1, K_UP,    1, WRAP ? 2 : 0,  SC_MENU,  0, 0};
    tbl[2]  = '{1'b1, K_DOWN,  1, WRAP ? 0 : 1,  SC_MENU,  0, 0};
    tbl[3]  = '{1'b1, K_DOWN,  1, WRAP ? 1 : 2,  SC_MENU,  0, 0};
    tbl[4]  = '{1'b1, K_DOWN,  1, 2,             SC_MENU,  0, 0};
    tbl[5]  = '{1'b1, K_DOWN,  1, WRAP ? 0 : 2,  SC_MENU,  0, 0};
    tbl[6]  = '{1'b1, K_UP,    1, WRAP ? 2 : 1,  SC_MENU,  0, 0};
    tbl[7]  = '{1'b1, K_UP,    1, WRAP ? 1 : 0,  SC_MENU,  0, 0};
    tbl[8]  = '{1'b1, K_UP,    1, 0,             SC_MENU,  0, 0};
    tbl[9]  = '{1'b1, 8'h1C,   1, 0,             SC_MENU,  0, 0};
    tbl[10] = '{1'b1, K_ESC,   1, 0,             SC_MENU,  0, 0};
    tbl[11] = '{1'b1, K_ENTER, 1, 0,             SC_BLANK, 0, 0};
    tbl[12] = '{1'b0, 8'h00,   3, 0,             SC_BLANK, 0, 0};
    tbl[13] = '{1'b0, 8'h00,   1, 0,             SC_GAME,  1, 0};
    tbl[14] = '{1'b1, K_DOWN,  1, 0,             SC_GAME,  0, 0};
    tbl[15] = '{1'b1, K_ESC,   1, 0,             SC_PAUSE, 0, 0};
    tbl[16] = '{1'b1, K_ESC,   1, 0,             SC_GAME,  0, 0};
    tbl[17] = '{1'b1, K_ESC,   1, 0,             SC_PAUSE, 0, 0};
    tbl[18] = '{1'b1, K_ENTER, 1, 0,             SC_MENU,  0, 0};
    tbl[19] = '{1'b1, K_DOWN,  1, 1,             SC_MENU,  0, 0};
    tbl[20] = '{1'b1, K_DOWN,  1, 2,             SC_MENU,  0, 0};
    tbl[21] = '{1'b1, K_ENTER, 1, 2,             SC_MENU,  0, 1};

    do_reset();
    cycle();
    check("reset_sel", sel_idx, 0);
    check("reset_screen", screen_sel, SC_MENU);
    check("reset_pulses", {game_start, exit_req}, 0);
    check("reset_ready", key_ready, 1);

    foreach (tbl[i]) begin
      n_start = 0;
      n_exit  = 0;
      key_valid = tbl[i].has_key;
      key_code  = tbl[i].code;
      repeat (tbl[i].frames) frame();
      check($sformatf("row%0d_sel", i), sel_idx, tbl[i].sel);
      check($sformatf("row%0d_screen", i), screen_sel, tbl[i].scr);
      check($sformatf("row%0d_starts", i), n_start, tbl[i].starts);
      check($sformatf("row%0d_exits", i), n_exit, tbl[i].exits);
    end

    // Two Downs in one frame: the second stalls until the tick has committed the first.
    do_reset();
    key_valid = 1'b1; key_code = K_DOWN;
    cycle();
    key_valid = 1'b1; key_code = K_DOWN;
    repeat (3) cycle();
    check("stall_ready", key_ready, 0);
    check("stall_sel", sel_idx, 0);
    vblnk_in = 1'b1;
    cycle();
    check("tick_sel", sel_idx, 1);
    check("ready_after_tick", key_ready, 1);
    repeat (2) cycle();
    vblnk_in = 1'b0;
    repeat (6) cycle();
    vblnk_in = 1'b1;
    repeat (2) cycle();
    check("second_down_sel", sel_idx, 2);

    // Reset in the second CONFIRM frame aborts without a game_start.
    do_reset();
    n_start = 0;
    key_valid = 1'b1; key_code = K_ENTER;
    frame();
    check("confirm_screen", screen_sel, SC_BLANK);
    key_valid = 1'b1; key_code = K_ESC;
    frame();
    vblnk_in = 1'b0;
    repeat (3) cycle();
    check("confirm_hold_ready", key_ready, 0);
    rst = 1'b1;
    cycle();
    check("abort_sel", sel_idx, 0);
    check("abort_screen", screen_sel, SC_MENU);
    check("abort_pulses", {game_start, exit_req}, 0);
    rst = 1'b0;
    key_valid = 1'b0;
    repeat (6) frame();
    check("abort_no_start", n_start, 0);
    check("abort_menu", screen_sel, SC_MENU);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) vblnk_in = ~vblnk_in;
      if (!key_valid && $urandom_range(0, 3) == 0) begin
        key_valid = 1'b1;
        case ($urandom_range(0, 5))
          0:       key_code = K_UP;
          1:       key_code = K_DOWN;
          2:       key_code = K_ENTER;
          3, 4:    key_code = K_ESC;
          default: key_code = 8'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
- Menu sequencer for the 800x600 VGA frontend.
- Consumes decoded keyboard events over a valid/ready handshake and runs the menu state machine (MENU, CONFIRM, GAME, PAUSE).
- Drives the screen-select and highlighted-item signals that the draw layers and the final RGB mux use.
- Applies every visible change only at the start of vertical blanking, so no frame shows a mid-frame update.

Parameters:
- ITEMS, 3: number of selectable menu entries (2..4). Item 0 is "Start", item ITEMS-1 is "Exit".
- CONFIRM_FRAMES, 30: frames spent in CONFIRM (transition delay) before GAME is entered.
- IDX_W, 2: width of the item index.

Ports:
- clk  in  1  pixel clock, 40 MHz.
- rst  in  1  synchronous, active-high reset.
- vblnk_in  in  1  vertical blanking from the timing generator.
- key_valid  in  1  a key event is present on key_code.
- key_code  in  8  PS/2 make code. Up 8'h75, Down 8'h72, Enter 8'h5A, Esc 8'h76. All other codes are ignored.
- key_ready  out  1  block accepts the key event this cycle.
- sel_idx  out  IDX_W  highlighted menu item; frame-synchronous.
- screen_sel  out  2  display source: 0 = menu, 1 = game, 2 = pause overlay, 3 = blank.
- game_start  out  1  one-cycle pulse when GAME is entered from CONFIRM.
- exit_req  out  1  one-cycle pulse when Enter is pressed on item ITEMS-1.

Behaviour:
- Reset: state = MENU, sel_idx = 0, pending index = 0, screen_sel = 0, game_start = 0, exit_req = 0, frame counter = 0, key_ready = 0 during the reset cycle. Reset mid-operation aborts CONFIRM/GAME immediately; no game_start pulse is emitted.
- Frame tick: vblnk_in is registered once; tick = vblnk_in & ~vblnk_q, the first cycle of vertical blanking.
- Handshake: a key is accepted on a cycle where key_valid & key_ready.
  - key_ready = 1 in MENU, GAME and PAUSE when no key is latched.
  - key_ready = 0 in CONFIRM and while a latched key awaits commit.
  - At most one key is latched per frame. The latched key is consumed on the next tick, and key_ready returns high in the cycle after the tick.
  - key_valid while key_ready = 0 is not consumed; the source holds it.
- Commit on tick, per state:
  - MENU
    - Up: pending index -1. Down: pending index +1. Bound behaviour at the ends is set by MENU_WRAP_EN.
    - Enter on item 0 -> CONFIRM, frame counter cleared, screen_sel = 3.
    - Enter on item ITEMS-1 -> exit_req pulse; state stays MENU.
    - Enter on any other item: no state change.
    - Esc: ignored.
  - CONFIRM
    - Counter increments once per tick.
    - When the counter reaches CONFIRM_FRAMES-1 on a tick -> GAME, screen_sel = 1, game_start pulses in that same cycle.
  - GAME
    - Esc -> PAUSE, screen_sel = 2. All other keys are ignored but still consumed.
  - PAUSE
    - Esc -> GAME, screen_sel = 1.
    - Enter -> MENU, screen_sel = 0, pending index and sel_idx reset to 0.
- sel_idx updates only on tick, from the pending index. Latency from key acceptance to visible change is the next tick, with output registered 1 cycle after the tick.
- A key accepted in the same cycle as the tick is committed on the following tick. It is never merged into the current one.
- Unknown codes are accepted and discarded with no state change.
- Output regs: screen_sel and sel_idx are registered. game_start and exit_req are registered single-cycle pulses.

Optional Feature:
- Macro: MENU_WRAP_EN.
- Defined: Up at index 0 goes to ITEMS-1; Down at ITEMS-1 goes to 0.
- Undefined: the index saturates at 0 and ITEMS-1, and the key is consumed with no change.

Decomposition:
- Package menu_pkg holds:
  - state enum: MENU, CONFIRM, GAME, PAUSE;
  - screen_sel codes: SCR_MENU, SCR_GAME, SCR_PAUSE, SCR_BLANK;
  - key code localparams: KEY_UP, KEY_DOWN, KEY_ENTER, KEY_ESC.
- One sub-module, frame_tick: registers vblnk_in and outputs the rising-edge tick. It is reused by other frame-synchronous blocks.

Test Plan:
- Reset release, no keys, 3 frames -> screen_sel = 0, sel_idx = 0, key_ready = 1, no pulses.
- Down (8'h72) accepted mid-frame, then a second Down offered in the same frame:
  - sel_idx = 1 after the next tick;
  - second key stalled (key_ready = 0) until after that tick;
  - sel_idx = 2 one frame later.
- Up at index 0:
  - with MENU_WRAP_EN -> sel_idx = 2 after tick;
  - without it -> sel_idx stays 0 and the key is consumed.
- Enter at index 0, CONFIRM_FRAMES = 4:
  - screen_sel = 3 on the next tick;
  - key_valid is held but not accepted;
  - exactly 4 ticks later, game_start pulses 1 cycle and screen_sel = 1.
- In GAME: Esc -> screen_sel = 2 next tick; Enter -> screen_sel = 0, sel_idx = 0 next tick.
- Enter at index 2 -> exit_req single pulse, state stays MENU. Assert rst during CONFIRM frame 2 -> all outputs at reset values next cycle, no game_start.
